// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported 32-bit SRAM between instruction fetch and data memory stages.
// Fixed-latency access sequenced by a wait-state counter; all outputs come straight from flops.
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  sel
);

    localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);

    localparam logic [1:0] SelIf   = 2'b00;
    localparam logic [1:0] SelDm   = 2'b01;
    localparam logic [1:0] SelIdle = 2'b10;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_dm_q, last_dm_d;
    logic              gnt_dm_q, gnt_dm_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [1:0]        sel_q, sel_d;
    logic              pick_dm;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_dm_d  = last_dm_q;
        gnt_dm_d   = gnt_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        mem_en_d   = mem_en_q;
        mem_we_d   = mem_we_q;
        sel_d      = sel_q;
        // DM wins contention unless it won the previous grant
        pick_dm    = dm_req && (!if_req || !last_dm_q);

        case (state_q)
            StIdle: begin
                if (if_req || dm_req) begin
                    state_d   = StAccess;
                    cnt_d     = CntW'(WAIT_CYCLES - 1);
                    gnt_dm_d  = pick_dm;
                    last_dm_d = pick_dm;
                    we_d      = pick_dm && dm_we;
                    addr_d    = pick_dm ? dm_addr : if_addr;
                    if (pick_dm) begin
                        wdata_d = dm_wdata;
                    end
                    mem_en_d  = 1'b1;
                    mem_we_d  = pick_dm && dm_we;
                    sel_d     = pick_dm ? SelDm : SelIf;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d    = StDone;
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    sel_d      = SelIdle;
                    if_ready_d = !gnt_dm_q;
                    dm_ready_d = gnt_dm_q;
                    if (!we_q) begin
                        if (gnt_dm_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_dm_q  <= 1'b0;
            gnt_dm_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            sel_q      <= SelIdle;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dm_q  <= last_dm_d;
            gnt_dm_q   <= gnt_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            sel_q      <= sel_d;
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with WAIT_CYCLES=4, one with WAIT_CYCLES=1.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [1:0]  sel;

    logic        b_if_req, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
    logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  b_sel;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.WAIT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .sel(sel)
    );

    mem_port_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_ready(b_dm_ready), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .sel(b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        b_if_req = 0; b_dm_req = 0; b_dm_we = 0;
        b_if_addr = '0; b_dm_addr = '0; b_dm_wdata = '0; b_mem_rdata = '0;

        step(); step();
        check("rst_sel", sel, 2'b10);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_dm_ready", dm_ready, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        step();

        // T1: IF read, ready at c5
        if_req = 1; if_addr = 32'h100; mem_rdata = 32'hE3A0_1005;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t1_mem_en", mem_en, (k <= 4));
            check("t1_mem_we", mem_we, 0);
            check("t1_sel", sel, (k <= 4) ? 2'b00 : 2'b10);
            check("t1_if_ready", if_ready, (k == 5));
            check("t1_dm_ready", dm_ready, 0);
            if (k == 1) check("t1_mem_addr", mem_addr, 32'h100);
        end
        check("t1_if_rdata", if_rdata, 32'hE3A0_1005);
        if_req = 0;
        step();
        check("t1_ready_drop", if_ready, 0);

        // T3: both held, grants alternate DM, IF, DM, IF every 6 cycles
        if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h800; mem_rdata = 32'h0BAD_F00D;
        for (int k = 1; k <= 24; k++) begin
            int j;
            int pos;
            logic dm_turn;
            step();
            j = (k - 1) / 6;
            pos = (k - 1) % 6 + 1;
            dm_turn = (j % 2 == 0);
            check("t3_mem_en", mem_en, (pos <= 4));
            check("t3_sel", sel, (pos <= 4) ? (dm_turn ? 2'b01 : 2'b00) : 2'b10);
            check("t3_dm_ready", dm_ready, (pos == 5) && dm_turn);
            check("t3_if_ready", if_ready, (pos == 5) && !dm_turn);
            if (pos == 1) check("t3_mem_addr", mem_addr, dm_turn ? 32'h800 : 32'h100);
            if (k == 23) begin
                if_req = 0; dm_req = 0;
            end
        end
        check("t3_dm_rdata", dm_rdata, 32'h0BAD_F00D);
        check("t3_if_rdata", if_rdata, 32'h0BAD_F00D);

        // T2: DM write, rdata registers untouched
        dm_req = 1; dm_we = 1; dm_addr = 32'h400; dm_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h1234_5678;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t2_mem_we", mem_we, (k <= 4));
            check("t2_mem_en", mem_en, (k <= 4));
            check("t2_sel", sel, (k <= 4) ? 2'b01 : 2'b10);
            check("t2_dm_ready", dm_ready, (k == 5));
            check("t2_if_ready", if_ready, 0);
            if (k == 1) begin
                check("t2_mem_addr", mem_addr, 32'h400);
                check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
        end
        check("t2_dm_rdata", dm_rdata, 32'h0BAD_F00D);
        check("t2_if_rdata", if_rdata, 32'h0BAD_F00D);
        dm_req = 0; dm_we = 0;
        step();

        // T5: DM read with req dropped after c1
        dm_req = 1; dm_we = 0; dm_addr = 32'h500; mem_rdata = 32'hCAFE_F00D;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) dm_req = 0;
            check("t5_mem_en", mem_en, (k <= 4));
            check("t5_dm_ready", dm_ready, (k == 5));
        end
        check("t5_dm_rdata", dm_rdata, 32'hCAFE_F00D);
        check("t5_if_rdata", if_rdata, 32'h0BAD_F00D);
        step();
        step();
        check("t5_idle_mem_en", mem_en, 0);
        check("t5_idle_sel", sel, 2'b10);

        // T4: reset in ACCESS cycle 2
        if_req = 1; if_addr = 32'h200; mem_rdata = 32'h5555_AAAA;
        step(); step();
        check("t4_pre_mem_en", mem_en, 1);
        #1 rst = 1'b0;
        #1;
        check("t4_rst_mem_en", mem_en, 0);
        check("t4_rst_mem_we", mem_we, 0);
        check("t4_rst_sel", sel, 2'b10);
        if_req = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_no_ready", if_ready, 0);
        end
        check("t4_if_rdata", if_rdata, 0);
        rst = 1'b1;
        if_req = 1; if_addr = 32'h240; mem_rdata = 32'h7777_8888;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t4_if_ready", if_ready, (k == 5));
            if (k == 1) check("t4_mem_addr", mem_addr, 32'h240);
        end
        check("t4_if_rdata2", if_rdata, 32'h7777_8888);
        step();
        dm_req = 1; dm_addr = 32'h600;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) check("t4_contend_sel", sel, 2'b01);
            check("t4_contend_dm_ready", dm_ready, (k == 5));
            check("t4_contend_if_ready", if_ready, 0);
        end
        if_req = 0; dm_req = 0;
        step();

        // T6: WAIT_CYCLES=1, IF held
        b_if_req = 1; b_if_addr = 32'h300; b_mem_rdata = 32'h1111_2222;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("t6_mem_en", b_mem_en, (k % 3 == 1));
            check("t6_if_ready", b_if_ready, (k % 3 == 2));
            check("t6_sel", b_sel, (k % 3 == 1) ? 2'b00 : 2'b10);
            check("t6_mem_we", b_mem_we, 0);
            check("t6_dm_ready", b_dm_ready, 0);
            if (k == 1) check("t6_mem_addr", b_mem_addr, 32'h300);
            if (k == 2) check("t6_if_rdata", b_if_rdata, 32'h1111_2222);
        end
        check("t6_dm_rdata", b_dm_rdata, 0);
        check("t6_mem_wdata", b_mem_wdata, 0);
        b_if_req = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
